// File: rtl/divider_if.sv
// Request/response handshake bundle for the iterative divide unit.
interface divider_if #(parameter int N = 32);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   op;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] out;

  modport master (
    output req_valid, op, in1, in2, resp_ready,
    input  req_ready, resp_valid, out
  );

  modport slave (
    input  req_valid, op, in1, in2, resp_ready,
    output req_ready, resp_valid, out
  );
endinterface

// File: rtl/divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one restoring step per cycle.
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUSY  | one restoring division step per edge
// DONE  | result held on out, resp_valid high until resp_ready
module divider #(
  parameter int N = 32
) (
  input logic       clk,
  input logic       reset,
  divider_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;
  logic          is_rem_q, is_rem_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic          signed_op;
  logic [N-1:0]  abs1, abs2;
  logic [N:0]    shifted, trial;
  logic [N-1:0]  step_rem, step_quo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    signed_op = ~bus.op[0];
    abs1      = (signed_op && bus.in1[N-1]) ? -bus.in1 : bus.in1;
    abs2      = (signed_op && bus.in2[N-1]) ? -bus.in2 : bus.in2;

    // The N+1 bit trial difference keeps the borrow visible in its top bit.
    shifted  = {rem_q, quo_q[N-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    step_quo = {quo_q[N-2:0], ~trial[N]};

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          is_rem_d = bus.op[1];
          if (bus.in2 == '0) begin
            out_d   = bus.op[1] ? bus.in1 : '1;
            state_d = DONE;
          end else if (signed_op && bus.in1 == MIN_NEG && bus.in2 == '1) begin
            out_d   = bus.op[1] ? '0 : bus.in1;
            state_d = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = abs1;
            dvs_d     = abs2;
            cnt_d     = '0;
            neg_quo_d = signed_op && (bus.in1[N-1] ^ bus.in2[N-1]);
            neg_rem_d = signed_op && bus.in1[N-1];
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (is_rem_q) out_d = neg_rem_q ? -step_rem : step_rem;
          else          out_d = neg_quo_q ? -step_quo : step_quo;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.out        = out_q;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed table, corner sequences, random ops vs model.
module tb_divider;
  localparam int N = 32;
  localparam int NORM_LAT = N + 1;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  divider_if #(.N(N)) bus ();

  divider #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return NORM_LAT;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns after the response handshake.
  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bus.req_valid = 1'b1;
    bus.op        = op;
    bus.in1       = a;
    bus.in2       = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.op        = 2'($urandom);
    bus.in1       = $urandom;
    bus.in2       = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " out"}, bus.out, exp);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({name, " idle after resp"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
  endtask

  vec_t vt[$];

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, held;
    int          w;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.op  = 2'b00;
    bus.in1 = '0;
    bus.in2 = '0;

    vt.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         NORM_LAT});
    vt.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          NORM_LAT});
    vt.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORM_LAT});
    vt.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORM_LAT});
    vt.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          NORM_LAT});
    vt.push_back('{2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1});
    vt.push_back('{2'b10, 32'd5,          32'd0,          32'd5,          1});
    vt.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vt.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vt.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NORM_LAT});
    vt.push_back('{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          NORM_LAT});
    vt.push_back('{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  NORM_LAT});
    vt.push_back('{2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  NORM_LAT});
    vt.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          NORM_LAT});
    vt.push_back('{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         NORM_LAT});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset state", {29'd0, bus.req_ready, bus.resp_valid, |bus.out}, 32'b100);

    for (int i = 0; i < vt.size(); i++)
      run($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

    // Back-pressure: out must hold and no new request may sneak in.
    held = 32'hDEAD_BEEF / 32'h10;
    bus.req_valid = 1'b1;
    bus.op  = 2'b01;
    bus.in1 = 32'hDEAD_BEEF;
    bus.in2 = 32'h10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    w = 1;
    while (!bus.resp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("bp latency", 32'(w), 32'(NORM_LAT));
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = ~bus.req_valid;
      bus.in1 = $urandom;
      bus.in2 = $urandom & 32'hF;
      @(negedge clk);
      chk($sformatf("bp hold %0d", k),
          {bus.out[31:2], bus.req_ready, bus.resp_valid}, {held[31:2], 2'b01});
      chk($sformatf("bp out lsb %0d", k), {30'd0, bus.out[1:0]}, {30'd0, held[1:0]});
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("bp release flags", {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
    chk("bp release out", bus.out, held);
    run("after bp", 2'b00, 32'hFFFF_FF00, 32'd16, 32'hFFFF_FFF0, NORM_LAT);

    // Reset in the middle of BUSY abandons the operation.
    bus.req_valid = 1'b1;
    bus.op  = 2'b01;
    bus.in1 = 32'd1000;
    bus.in2 = 32'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy before reset", {30'd0, bus.req_ready, bus.resp_valid}, 32'b00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid-busy reset", {29'd0, bus.req_ready, bus.resp_valid, |bus.out}, 32'b100);
    w = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.resp_valid) w++;
    end
    chk("no resp after reset", 32'(w), 32'd0);
    run("fresh divu", 2'b01, 32'd9, 32'd3, 32'd3, NORM_LAT);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = $urandom_range(1, 15);
        3:       rb = -$urandom_range(1, 15);
        4:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 0 && $urandom_range(0, 1) == 1) rb = 32'd1;
      run($sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb), rop, ra, rb,
          ref_result(rop, ra, rb), ref_latency(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Iterative RV32M divide/remainder unit with valid/ready handshakes on request and response. It sits beside the single-cycle ALU in the execute stage and handles DIV, DIVU, REM and REMU, which the combinational datapath does not implement. It uses one restoring-division step per cycle and stalls the pipeline through its handshake. Divide-by-zero and signed overflow complete early with the architecturally defined results.

## Interface

- N, default 32: operand and result width in bits.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- in1  in  N  dividend.
- in2  in  N  divisor.
- resp_valid  out  1  result available; high only in DONE.
- resp_ready  in  1  consumer takes the result.
- out  out  N  quotient or remainder, registered.

## Operation

- States: IDLE, BUSY, DONE. Reset enters IDLE with out = 0, resp_valid = 0, req_ready = 1, and clears the internal counter.
- A request is accepted on an edge where req_valid and req_ready are both high. The unit latches op, in1 and in2 on that edge.
- Special cases are checked on the accept edge and go directly to DONE:
  - Divisor 0: quotient = all ones; remainder = in1.
  - Signed overflow (DIV/REM, in1 = 1 followed by N-1 zeros, in2 = all ones): quotient = in1; remainder = 0.
- Normal path, on the accept edge:
  - For DIV/REM, the unit takes the absolute values of the operands.
  - The partial remainder is cleared; the quotient register is loaded with |dividend|. The counter is set to 0. The state goes to BUSY.
- Each BUSY edge performs one restoring step:
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and set quotient bit 0 to 1; otherwise restore.
  - Increment the counter.
- The step with counter = N-1 is the last one and moves the state to DONE. On that same edge, out gets the sign-corrected result:
  - Quotient is negated if DIV and the operand signs differ.
  - Remainder is negated if REM and the dividend is negative.
  - Unsigned ops take no correction.
- Intermediate remainder width is N+1 bits, so the trial subtract cannot overflow. The counter is ceil(log2 N) bits.
- In DONE, out and resp_valid are held until resp_ready is high. On that edge the state goes to IDLE. out keeps its value; only resp_valid drops.
- req_ready is low in BUSY and DONE. A request cannot be accepted on the same edge as a response handshake.
- req_valid, op, in1 and in2 are ignored outside IDLE. Changes to them after acceptance have no effect.
- Reset in any state, including mid-BUSY, abandons the operation and returns to reset values on that edge. No response is produced for the abandoned request.
- Operand value x (all bits unknown) is not supported. There is no cancel input.

## Timing

- Accept in cycle t (edge at end of t):
  - Normal path: BUSY in cycles t+1 … t+N; resp_valid high from cycle t+N+1.
  - Special case: resp_valid high from cycle t+1.
- Minimum issue interval: N+2 cycles (normal) or 2 cycles (special), with resp_ready held high.
- All outputs are decoded from state and registers, with no combinational path from inputs to outputs. req_ready = (state == IDLE); resp_valid = (state == DONE).
- While resp_ready is low, out stays bit-stable in DONE for any number of cycles.

## Test plan

- DIVU 100 / 7 -> out = 14, resp_valid exactly 33 cycles after the accept edge cycle (N=32). REMU same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE -> 1.
- DIVU 0x12345678 / 0 -> 0xFFFFFFFF. REM 5 / 0 -> 5. Both have resp_valid in the cycle after accept.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Both have 1-cycle latency.
- Back-pressure: hold resp_ready low for 5 cycles in DONE while toggling req_valid, in1 and in2 -> out stable, req_ready 0, no second accept. Raise resp_ready -> IDLE on the next edge, and a new request is accepted in the following cycle.
- Assert reset at BUSY cycle 10 of DIVU 1000 / 3 -> next cycle IDLE, out = 0, resp_valid = 0. A fresh DIVU 9 / 3 then returns 3 with normal latency.
